conv2d_stream: RTL and testbench
================================

Name: conv2d_stream

Overview:
Parametrised streaming 2-D convolution engine. It is the successor to the fixed 3x3 / 8-bit filter FSM and generalises image size, kernel size and data widths. It adds valid/ready backpressure on both sides, signed coefficients, output scaling with ReLU and saturation, and multi-frame operation. It sits between the pixel DMA/stream source and the next layer or pooling stage.

Parameters:
DATA_W, 8, unsigned pixel width (input and output)
COEF_W, 16, signed two's-complement coefficient width
K, 3, kernel side length (K>=2); the kernel has K*K taps
IMG_W, 28, input image width in pixels
IMG_H, 28, input image height in pixels
ACC_W, 32, accumulator width; must hold DATA_W+COEF_W+clog2(K*K) bits
SHIFT, 8, arithmetic right shift applied to the accumulator before output
RELU, 1, 1 = clamp negative results to 0; 0 = negative results saturate to 0 anyway (unsigned output), with no ReLU stage

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
k_val_i  in  K*K*COEF_W  coefficients, tap 0 (top-left) in the LSBs, row-major
k_load_i  in  1  capture k_val_i (honoured only in IDLE)
pixel_i  in  DATA_W  input pixel, raster order
pix_valid_i  in  1  input pixel valid
pix_ready_o  out  1  input ready
pixel_o  out  DATA_W  output pixel
pix_valid_o  out  1  output valid
pix_ready_i  in  1  downstream ready
conv_finished_o  out  1  one-cycle pulse on the last output handshake of a frame
kernel_constructed_o  out  1  coefficients are valid

Behaviour:
- Reset (asynchronous, any state including mid-frame): state=IDLE; counters, line buffers and pipeline valid bits cleared; all outputs 0; coefficients cleared; kernel_constructed_o=0.
- States:
  - IDLE -> STREAM when kernel_constructed_o=1.
  - STREAM -> DRAIN after the input handshake of the last pixel (row IMG_H-1, col IMG_W-1).
  - DRAIN -> IDLE on the last output handshake.
- Kernel load: k_load_i=1 in IDLE registers k_val_i. kernel_constructed_o rises the next cycle and stays high until reset. k_load_i in STREAM/DRAIN is ignored. The kernel is retained across frames.
- Input handshake occurs when pix_valid_i && pix_ready_o.
- pix_ready_o = (state==STREAM) && !stall, where stall = pix_valid_o && !pix_ready_i.
- The whole pipeline freezes while stall=1, with no data loss or duplication.
- Window storage:
  - K-1 line buffers of IMG_W entries plus a KxK window register file, shifted on each input handshake.
  - col/row counters wrap at IMG_W-1 / IMG_H-1.
- Valid convolution, no padding:
  - A window is produced when the accepted pixel has row>=K-1 and col>=K-1.
  - Output count per frame is (IMG_W-K+1)*(IMG_H-K+1), in raster order.
  - Windows never straddle a row wrap.
- Arithmetic:
  - Each product is pixel (zero-extended) x coef (signed).
  - Products are summed signed in ACC_W.
  - The sum is arithmetically shifted right by SHIFT.
  - Negative results give 0. Results above 2^DATA_W-1 give 2^DATA_W-1.
- Latency: 2 pipeline stages.
  - Stage 1: registered products.
  - Stage 2: adder tree plus scaling, registered to pixel_o.
  - pix_valid_o rises 2 cycles after the completing input handshake when no stall occurs.
- pixel_o and pix_valid_o hold steady while pix_valid_o && !pix_ready_i.
- conv_finished_o pulses in the cycle after the final output handshake; the block is back in IDLE that same cycle.
- Simultaneous k_load_i and pix_valid_i in IDLE: the load wins; pix_ready_o=0 that cycle.
- A new frame may start the cycle after IDLE is re-entered.

Decomposition:
- Package conv_pkg:
  - state enum (IDLE, STREAM, DRAIN)
  - localparam-style function n_out(IMG_W, IMG_H, K)
  - sat_scale function (shift, ReLU, clamp)
  - coefficient unpack helper
- Sub-module conv_line_buffer: K-1 row delay lines, parametrised DATA_W/IMG_W/K, with shift enable, exposing a K-tall column per shift.

Test Plan:
- Bench configuration: IMG_W=IMG_H=5, K=3, SHIFT=8, unless a scenario says otherwise.
1. Identity kernel (centre=256, others 0), ramp p(r,c)=5r+c, ready always 1 -> outputs 6,7,8,11,12,13,16,17,18, then one conv_finished_o pulse.
2. Box kernel (all coefficients 1, SHIFT=0) on the same ramp -> first output 54, last output 162; all pixels 200 -> every output 255 (saturation).
3. Kernel of all -1, RELU=1, ramp input -> nine outputs of 0; the frame completes normally.
4. Backpressure: pix_ready_i toggles 1,0,0,1,... on scenario 1 -> identical output sequence; pixel_o stable while stalled; pix_ready_o low during stalls.
5. Assert rst_i after 12 input pixels -> all outputs 0 and kernel_constructed_o=0 immediately. A reload plus full frame then gives the scenario-1 outputs.
6. k_load_i with a different kernel during STREAM -> ignored; outputs still match scenario 1. A back-to-back second frame produces the same nine values.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming 2-D convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } conv_state_e;

    // Number of valid (unpadded) output pixels per frame.
    function automatic int n_out(input int img_w, input int img_h, input int k);
        return (img_w - k + 1) * (img_h - k + 1);
    endfunction

    // Sign-extend a coef_w-bit two's-complement field held in the low bits of raw.
    function automatic logic signed [63:0] coef_sext(input logic [63:0] raw, input int coef_w);
        logic signed [63:0] v;
        v = $signed(raw << (64 - coef_w));
        return v >>> (64 - coef_w);
    endfunction

    // Scale the accumulator down, apply ReLU, then clamp into the unsigned output range.
    function automatic logic [31:0] sat_scale(input logic signed [63:0] acc, input int shift,
                                              input bit relu, input int data_w);
        logic signed [63:0] s;
        logic signed [63:0] max_v;
        s     = acc >>> shift;
        max_v = (64'sd1 <<< data_w) - 64'sd1;
        if (relu && s < 64'sd0) s = '0;
        // The output is unsigned, so anything still negative floors at zero.
        if (s < 64'sd0)  return '0;
        if (s > max_v)   return max_v[31:0];
        return s[31:0];
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 chained row delay lines; presents the K-tall pixel column ending at the incoming pixel.
module conv_line_buffer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int K      = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                shift_i,
    input  logic [DATA_W-1:0]   pixel_i,
    output logic [K*DATA_W-1:0] column_o
);
    import conv_pkg::*;

    logic [DATA_W-1:0] line_q [K-1][IMG_W];

    // Shift every delay line by one pixel per accepted input; line j+1 is fed from the tail of line j.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the delay lines are cleared on reset so a restarted frame never sees old pixels;
            // this forces flops rather than a RAM macro, which is acceptable at these row lengths.
            for (int j = 0; j < K-1; j++) begin
                for (int i = 0; i < IMG_W; i++) begin
                    line_q[j][i] <= '0;
                end
            end
        end else if (shift_i) begin
            // NOTE: non-blocking assignments let every stage read its neighbour's old value,
            // so the order of these statements does not matter.
            line_q[0][0] <= pixel_i;
            for (int j = 1; j < K-1; j++) begin
                line_q[j][0] <= line_q[j-1][IMG_W-1];
            end
            for (int j = 0; j < K-1; j++) begin
                for (int i = 1; i < IMG_W; i++) begin
                    line_q[j][i] <= line_q[j][i-1];
                end
            end
        end
    end

    // Assemble the column: index 0 is the oldest row, index K-1 is the live pixel.
    always_comb begin
        // NOTE: a default assignment first guarantees no path leaves the output unassigned (no latch).
        column_o = '0;
        column_o[(K-1)*DATA_W +: DATA_W] = pixel_i;
        for (int i = 0; i < K-1; i++) begin
            column_o[i*DATA_W +: DATA_W] = line_q[K-2-i][IMG_W-1];
        end
    end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming valid-mode 2-D convolution with valid/ready on both sides, signed taps,
// shift/ReLU/saturate output scaling and back-to-back frame support.
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 16,
    parameter int K      = 3,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ACC_W  = 32,
    parameter int SHIFT  = 8,
    parameter int RELU   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [K*K*COEF_W-1:0] k_val_i,
    input  logic                  k_load_i,
    input  logic [DATA_W-1:0]     pixel_i,
    input  logic                  pix_valid_i,
    output logic                  pix_ready_o,
    output logic [DATA_W-1:0]     pixel_o,
    output logic                  pix_valid_o,
    input  logic                  pix_ready_i,
    output logic                  conv_finished_o,
    output logic                  kernel_constructed_o
);

    localparam int TAPS  = K * K;
    localparam int N_OUT = n_out(IMG_W, IMG_H, K);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int OW    = $clog2(N_OUT + 1);

    conv_state_e             state_q;
    logic [CW-1:0]           col_q;
    logic [RW-1:0]           row_q;
    logic [OW-1:0]           out_cnt_q;
    logic [K*K*COEF_W-1:0]   coef_q;
    logic                    kc_q;
    logic                    done_q;

    logic [K*DATA_W-1:0]     column;
    logic [DATA_W-1:0]       win_q [K][K];
    logic [DATA_W-1:0]       win_d [K][K];

    logic signed [ACC_W-1:0] prod_q [TAPS];
    logic signed [ACC_W-1:0] prod_d [TAPS];
    logic                    s1_valid_q;
    logic signed [ACC_W-1:0] acc_d;
    logic [DATA_W-1:0]       pixel_q;
    logic [DATA_W-1:0]       pixel_d;
    logic                    valid_q;

    logic stall, in_hs, out_hs, last_col, last_row, win_ok, last_out;

    // A held output that downstream refuses freezes the whole pipeline.
    assign stall    = valid_q && !pix_ready_i;
    assign in_hs    = pix_valid_i && pix_ready_o;
    assign out_hs   = valid_q && pix_ready_i;
    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));
    assign win_ok   = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
    assign last_out = (out_cnt_q == OW'(N_OUT - 1));

    assign pix_ready_o          = (state_q == STREAM) && !stall;
    assign pixel_o              = pixel_q;
    assign pix_valid_o          = valid_q;
    assign conv_finished_o      = done_q;
    assign kernel_constructed_o = kc_q;

    // Frame control: kernel capture, raster counters, output count and state sequencing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            out_cnt_q <= '0;
            coef_q    <= '0;
            kc_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (in_hs) begin
                if (last_col) begin
                    col_q <= '0;
                    row_q <= last_row ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            if (out_hs) out_cnt_q <= out_cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    // Loading takes the cycle; input is never accepted in IDLE anyway.
                    if (k_load_i) begin
                        coef_q <= k_val_i;
                        kc_q   <= 1'b1;
                    end
                    if (kc_q) state_q <= STREAM;
                end
                STREAM: begin
                    if (in_hs && last_col && last_row) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (out_hs && last_out) begin
                        state_q   <= IDLE;
                        done_q    <= 1'b1;
                        out_cnt_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    conv_line_buffer #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .K      (K)
    ) u_line_buffer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .shift_i  (in_hs),
        .pixel_i  (pixel_i),
        .column_o (column)
    );

    // Window as it will look once the live column is shifted in, and its tap products.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K-1; j++) begin
                win_d[i][j] = win_q[i][j+1];
            end
            win_d[i][K-1] = column[i*DATA_W +: DATA_W];
        end
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                prod_d[i*K+j] = $signed(ACC_W'(win_d[i][j]))
                              * ACC_W'(coef_sext(64'(coef_q[(i*K+j)*COEF_W +: COEF_W]), COEF_W));
            end
        end
    end

    // Window register file: shifts one column left per accepted pixel.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else if (in_hs) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win_q[i][j] <= win_d[i][j];
                end
            end
        end
    end

    // Stage 2 combinational: sum the registered products and scale into the output range.
    always_comb begin
        acc_d = '0;
        for (int t = 0; t < TAPS; t++) begin
            acc_d = acc_d + prod_q[t];
        end
        pixel_d = DATA_W'(sat_scale(64'(acc_d), SHIFT, RELU != 0, DATA_W));
    end

    // Two-stage arithmetic pipeline; everything holds while the output is stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            valid_q    <= 1'b0;
            pixel_q    <= '0;
            for (int t = 0; t < TAPS; t++) begin
                prod_q[t] <= '0;
            end
        end else if (!stall) begin
            s1_valid_q <= in_hs && win_ok;
            if (in_hs && win_ok) begin
                for (int t = 0; t < TAPS; t++) begin
                    prod_q[t] <= prod_d[t];
                end
            end
            valid_q <= s1_valid_q;
            if (s1_valid_q) pixel_q <= pixel_d;
        end
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// Self-checking bench for conv2d_stream on a 5x5 image with a 3x3 kernel.
module tb_conv2d_stream;

    localparam int DATA_W = 8;
    localparam int COEF_W = 16;
    localparam int K      = 3;
    localparam int IMG_W  = 5;
    localparam int IMG_H  = 5;
    localparam int ACC_W  = 32;
    localparam int SHIFT  = 8;
    localparam int TAPS   = K * K;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NOUT   = (IMG_W - K + 1) * (IMG_H - K + 1);

    typedef logic [TAPS-1:0][COEF_W-1:0] kern_t;

    typedef struct packed {
        kern_t                         kern;
        logic [1:0]                    pat;      // 0 ramp 5r+c, 1 all 200
        logic [1:0]                    rdy;      // 0 always ready, 1 pattern 1,0,0
        logic                          load_mid; // reload attempt mid-stream + second frame
        logic [NOUT-1:0][DATA_W-1:0]   expv;
    } vec_t;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b0;
    logic [TAPS*COEF_W-1:0] k_val_i = '0;
    logic                  k_load_i = 1'b0;
    logic [DATA_W-1:0]     pixel_i = '0;
    logic                  pix_valid_i = 1'b0;
    logic                  pix_ready_o;
    logic [DATA_W-1:0]     pixel_o;
    logic                  pix_valid_o;
    logic                  pix_ready_i = 1'b0;
    logic                  conv_finished_o;
    logic                  kernel_constructed_o;

    int n_vec = 0;
    int n_bad = 0;

    int img [NPIX];
    int got_q [$];
    int exp_q [$];
    int exp_id  [NOUT] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
    int exp_box [NOUT] = '{54, 63, 72, 99, 108, 117, 144, 153, 162};
    vec_t tbl [6];

    conv2d_stream #(
        .DATA_W (DATA_W), .COEF_W (COEF_W), .K (K), .IMG_W (IMG_W), .IMG_H (IMG_H),
        .ACC_W (ACC_W), .SHIFT (SHIFT), .RELU (1)
    ) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .k_val_i              (k_val_i),
        .k_load_i             (k_load_i),
        .pixel_i              (pixel_i),
        .pix_valid_i          (pix_valid_i),
        .pix_ready_o          (pix_ready_o),
        .pixel_o              (pixel_o),
        .pix_valid_o          (pix_valid_o),
        .pix_ready_i          (pix_ready_i),
        .conv_finished_o      (conv_finished_o),
        .kernel_constructed_o (kernel_constructed_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic kern_t kern_fill(input int centre, input int other);
        kern_t k;
        for (int t = 0; t < TAPS; t++) k[t] = COEF_W'((t == TAPS/2) ? centre : other);
        return k;
    endfunction

    function automatic void set_img(input int pat);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                img[r*IMG_W + c] = (pat == 0) ? 5*r + c : (pat == 1) ? 200 : int'($urandom_range(0, 255));
    endfunction

    // Reference: direct valid-mode convolution over the whole image, then scale and clamp.
    function automatic void model(input kern_t kern);
        longint acc;
        exp_q.delete();
        for (int r = K-1; r < IMG_H; r++) begin
            for (int c = K-1; c < IMG_W; c++) begin
                acc = 0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        acc += longint'(img[(r-K+1+i)*IMG_W + (c-K+1+j)]) * longint'($signed(kern[i*K+j]));
                acc = acc >>> SHIFT;
                if (acc < 0) acc = 0;
                else if (acc > (1 << DATA_W) - 1) acc = (1 << DATA_W) - 1;
                exp_q.push_back(int'(acc));
            end
        end
    endfunction

    task automatic do_reset(input string tag);
        @(negedge clk_i);
        #1;
        rst_i = 1'b1;
        pix_valid_i = 1'b0;
        k_load_i = 1'b0;
        #1;
        check({tag, "_rst_pixel"}, pixel_o, 0);
        check({tag, "_rst_valid"}, pix_valid_o, 0);
        check({tag, "_rst_finished"}, conv_finished_o, 0);
        check({tag, "_rst_kc"}, kernel_constructed_o, 0);
        check({tag, "_rst_ready"}, pix_ready_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic load_kernel(input string tag, input kern_t kern);
        @(negedge clk_i);
        k_val_i = kern;
        k_load_i = 1'b1;
        pix_valid_i = 1'b1;
        pixel_i = DATA_W'(img[0]);
        #1;
        check({tag, "_load_wins"}, pix_ready_o, 0);
        @(negedge clk_i);
        k_load_i = 1'b0;
        pix_valid_i = 1'b0;
        check({tag, "_kc_high"}, kernel_constructed_o, 1);
    endtask

    // Streams img through the DUT and gathers outputs into got_q, checking stall holds,
    // finish pulse timing and (when unthrottled) the two-cycle latency on the way.
    task automatic run_frame(input string tag, input int rdy_mode, input bit rand_valid,
                             input bit load_mid, input int abort_at);
        int pidx = 0, nout = 0, cyc = 0, hs_first = -1, first_v = -1;
        bit prev_stall = 0, last_done = 0, done = 0, reloaded = 0, stall;
        logic [DATA_W-1:0] prev_pix = '0;
        got_q.delete();
        while (cyc < 2000) begin
            @(negedge clk_i);
            if (abort_at > 0 && pidx >= abort_at) begin
                pix_valid_i = 1'b0;
                break;
            end
            if (prev_stall) begin
                check({tag, "_hold_valid"}, pix_valid_o, 1);
                check({tag, "_hold_data"}, pixel_o, prev_pix);
            end
            if (last_done) begin
                check({tag, "_finish_pulse"}, conv_finished_o, 1);
                pix_valid_i = 1'b0;
                k_load_i = 1'b0;
                #1;
                check({tag, "_idle_ready"}, pix_ready_o, 0);
                done = 1;
                break;
            end else if (conv_finished_o) begin
                check({tag, "_finish_early"}, 1, 0);
            end
            if (pix_valid_o && first_v < 0) first_v = cyc;
            case (rdy_mode)
                0:       pix_ready_i = 1'b1;
                1:       pix_ready_i = (cyc % 3 == 0);
                default: pix_ready_i = ($urandom_range(0, 3) != 0);
            endcase
            if (pidx < NPIX && (!rand_valid || $urandom_range(0, 3) != 0)) begin
                pix_valid_i = 1'b1;
                pixel_i = DATA_W'(img[pidx]);
            end else begin
                pix_valid_i = 1'b0;
            end
            k_load_i = 1'b0;
            if (load_mid && pidx == 5 && !reloaded) begin
                k_val_i = kern_fill(-700, 123);
                k_load_i = 1'b1;
                reloaded = 1;
            end
            #1;
            stall = pix_valid_o && !pix_ready_i;
            if (stall) check({tag, "_ready_low_in_stall"}, pix_ready_o, 0);
            if (pix_valid_i && pix_ready_o) begin
                if (pidx == (K-1)*IMG_W + (K-1)) hs_first = cyc;
                pidx++;
            end
            if (pix_valid_o && pix_ready_i) begin
                got_q.push_back(int'(pixel_o));
                nout++;
                if (nout == NOUT) last_done = 1;
            end
            prev_stall = stall;
            prev_pix = pixel_o;
            cyc++;
        end
        k_load_i = 1'b0;
        if (abort_at == 0) begin
            check({tag, "_frame_done"}, done, 1);
            if (done && rdy_mode == 0 && !rand_valid)
                check({tag, "_latency"}, first_v - hs_first, 2);
        end
    endtask

    task automatic compare_frame(input string tag, input bit use_model, input vec_t v);
        int g, w;
        check({tag, "_count"}, got_q.size(), NOUT);
        for (int n = 0; n < NOUT; n++) begin
            g = (n < got_q.size()) ? got_q[n] : -1;
            w = use_model ? exp_q[n] : int'(v.expv[n]);
            check($sformatf("%s_out%0d", tag, n), g, w);
        end
    endtask

    initial begin
        kern_t rk;
        string tag;

        // Box filter expressed as 256 per tap under SHIFT=8: exactly the unit-coefficient sum.
        for (int i = 0; i < 6; i++) tbl[i] = '0;
        tbl[0].kern = kern_fill(256, 0);    tbl[0].pat = 0; tbl[0].rdy = 0;
        tbl[1].kern = kern_fill(256, 256);  tbl[1].pat = 0; tbl[1].rdy = 0;
        tbl[2].kern = kern_fill(256, 256);  tbl[2].pat = 1; tbl[2].rdy = 0;
        tbl[3].kern = kern_fill(-1, -1);    tbl[3].pat = 0; tbl[3].rdy = 0;
        tbl[4].kern = kern_fill(256, 0);    tbl[4].pat = 0; tbl[4].rdy = 1;
        tbl[5].kern = kern_fill(256, 0);    tbl[5].pat = 0; tbl[5].rdy = 0; tbl[5].load_mid = 1;
        for (int n = 0; n < NOUT; n++) begin
            tbl[0].expv[n] = DATA_W'(exp_id[n]);
            tbl[1].expv[n] = DATA_W'(exp_box[n]);
            tbl[2].expv[n] = 8'd255;
            tbl[3].expv[n] = 8'd0;
            tbl[4].expv[n] = DATA_W'(exp_id[n]);
            tbl[5].expv[n] = DATA_W'(exp_id[n]);
        end

        do_reset("init");

        for (int i = 0; i < 6; i++) begin
            tag = $sformatf("vec%0d", i);
            set_img(int'(tbl[i].pat));
            do_reset(tag);
            load_kernel(tag, tbl[i].kern);
            run_frame(tag, int'(tbl[i].rdy), 1'b0, tbl[i].load_mid, 0);
            compare_frame(tag, 1'b0, tbl[i]);
            if (tbl[i].load_mid) begin
                run_frame({tag, "_b2b"}, 0, 1'b0, 1'b0, 0);
                compare_frame({tag, "_b2b"}, 1'b0, tbl[i]);
            end
        end

        // Mid-frame asynchronous reset, then a clean reload and frame.
        foreach (exp_id[n]) ;
        set_img(0);
        do_reset("midrst");
        load_kernel("midrst", tbl[0].kern);
        run_frame("midrst_part", 0, 1'b0, 1'b0, 12);
        check("midrst_kc_before", kernel_constructed_o, 1);
        do_reset("midrst_hit");
        load_kernel("midrst_reload", tbl[0].kern);
        run_frame("midrst_full", 0, 1'b0, 1'b0, 0);
        compare_frame("midrst_full", 1'b0, tbl[0]);

        // Random images and kernels with random gaps and backpressure.
        for (int v = 0; v < 8; v++) begin
            tag = $sformatf("rand%0d", v);
            for (int t = 0; t < TAPS; t++) rk[t] = COEF_W'(int'($urandom_range(0, 400)) - 150);
            set_img(2);
            model(rk);
            do_reset(tag);
            load_kernel(tag, rk);
            run_frame(tag, 2, 1'b1, 1'b0, 0);
            compare_frame(tag, 1'b1, tbl[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
